fila_paradas: RTL and testbench

Stop queue feeding the elevator control unit. It accepts passenger requests as an origin floor followed by a destination floor and holds them as an ordered list of stops. It presents the head stop on `prox_parada`, where 0 means the queue is empty, and drops the head when the control unit pulses `shift`. It also flags whether the head stop is a pickup (origin) or a drop-off (destination), which drives the control unit's passenger-picked-up bookkeeping.

---
 rtl/fila_pkg.sv | 19 +
 rtl/fila_paradas_mem.sv | 42 ++++
 rtl/fila_paradas.sv | 158 +++++++++++++++
 tb/tb_fila_paradas.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared definitions for the elevator stop queue: FSM states and the "no stop" floor code.
// The entry layout {andar, origem} is declared where ANDAR_W is known.
package fila_pkg;

    // Request capture FSM: waiting for an origin, or holding one until its destination arrives.
    typedef enum logic {
        OCIOSO         = 1'b0,
        ESPERA_DESTINO = 1'b1
    } estado_t;

    // Floor code 0 never names a real floor; it marks an empty head or an invalid request.
    localparam int ANDAR_VAZIO = 0;

    // Free entries a commit needs: a plain pair, or only the destination when merged.
    function automatic int entradas_por_pedido(input logic coalescido);
        return coalescido ? 1 : 2;
    endfunction

endpackage

// File: rtl/fila_paradas_mem.sv
// Register file behind the stop queue: two write ports (tail, tail+1) and one head read port.
// With FILA_COALESCE_EN a second read port and a set-origem path on the previous tail entry exist.
module fila_paradas_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 5
) (
    input  logic                     clock,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] addr0,
    input  logic [W-1:0]             data0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] addr1,
    input  logic [W-1:0]             data1,
`ifdef FILA_COALESCE_EN
    input  logic                     set_origem,
    input  logic [$clog2(DEPTH)-1:0] addr_ult,
    output logic [W-1:0]             dado_ult,
`endif
    input  logic [$clog2(DEPTH)-1:0] addr_rd,
    output logic [W-1:0]             dado_rd
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the queue count alone decides which entries are valid,
    // so flushing only clears pointers and count and the storage maps to plain flops/RAM.
    always_ff @(posedge clock) begin
        if (we0) mem[addr0] <= data0;
        if (we1) mem[addr1] <= data1;
`ifdef FILA_COALESCE_EN
        // Bit 0 of an entry is its origem flag.
        if (set_origem) mem[addr_ult][0] <= 1'b1;
`endif
    end

    assign dado_rd = mem[addr_rd];

`ifdef FILA_COALESCE_EN
    assign dado_ult = mem[addr_ult];
`endif

endmodule

// File: rtl/fila_paradas.sv
// Stop queue: captures origin/destination requests as ordered stops, presents the head stop.
// Define FILA_COALESCE_EN to merge a new origin into a matching drop-off at the tail.
module fila_paradas
    import fila_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ANDAR_W = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       grava_origem,
    input  logic                       grava_destino,
    input  logic [ANDAR_W-1:0]         andar_entrada,
    input  logic                       shift,
    output logic [ANDAR_W-1:0]         prox_parada,
    output logic                       eh_origem,
    output logic                       vazia,
    output logic                       cheia,
    output logic [$clog2(DEPTH+1)-1:0] ocupacao,
    output logic                       erro
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ANDAR_W-1:0] VAZIO   = ANDAR_W'(ANDAR_VAZIO);

    typedef struct packed {
        logic [ANDAR_W-1:0] andar;
        logic               origem;
    } entrada_t;

    function automatic logic [PTR_W-1:0] avanca(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    estado_t            estado, estado_nx;
    logic [ANDAR_W-1:0] origem_pend, origem_pend_nx;
    logic [PTR_W-1:0]   cabeca, cauda, cauda_mais1;
    logic [CNT_W-1:0]   contagem, contagem_pos, contagem_nx, livres, necessarias;
    logic               flush, pop, destino_ok, commit, rejeita, coalesce;
    entrada_t           cabeca_ent, escrita0, escrita1;

    assign flush        = reset | clear;
    assign pop          = shift && (contagem != '0);
    // Free space for a commit is judged after a same-cycle pop.
    assign contagem_pos = contagem - CNT_W'(pop);
    assign livres       = DEPTH_C - contagem_pos;
    assign destino_ok   = (andar_entrada != VAZIO) && (andar_entrada != origem_pend);
    assign cauda_mais1  = avanca(cauda, 1);

`ifdef FILA_COALESCE_EN
    logic [PTR_W-1:0] cauda_ant;
    entrada_t         ultima;

    assign cauda_ant = (cauda == '0) ? PTR_W'(DEPTH - 1) : cauda - 1'b1;
    // The previous tail entry only exists if it survives this cycle's pop.
    assign coalesce  = (contagem_pos != '0) && (ultima.andar == origem_pend);
`else
    assign coalesce  = 1'b0;
`endif

    assign necessarias = CNT_W'(entradas_por_pedido(coalesce));

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        estado_nx      = estado;
        origem_pend_nx = origem_pend;
        commit         = 1'b0;
        rejeita        = 1'b0;
        if (!flush) begin
            case (estado)
                OCIOSO: begin
                    if (grava_origem && !grava_destino) begin
                        if (andar_entrada != VAZIO) begin
                            origem_pend_nx = andar_entrada;
                            estado_nx      = ESPERA_DESTINO;
                        end else begin
                            rejeita = 1'b1;
                        end
                    end
                end
                ESPERA_DESTINO: begin
                    if (grava_destino) begin
                        estado_nx = OCIOSO;
                        if (destino_ok && (livres >= necessarias)) commit  = 1'b1;
                        else                                       rejeita = 1'b1;
                    end else if (grava_origem) begin
                        // A zero origin would later be stored as a stop, so it is refused.
                        if (andar_entrada != VAZIO) origem_pend_nx = andar_entrada;
                        else                        rejeita        = 1'b1;
                    end
                end
                default: estado_nx = OCIOSO;
            endcase
        end
    end

    always_comb begin
        escrita1 = '{andar: andar_entrada, origem: 1'b0};
        if (coalesce) escrita0 = '{andar: andar_entrada, origem: 1'b0};
        else          escrita0 = '{andar: origem_pend,   origem: 1'b1};
    end

    assign contagem_nx = contagem_pos + (commit ? necessarias : CNT_W'(0));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (flush) begin
            estado      <= OCIOSO;
            origem_pend <= VAZIO;
            cabeca      <= '0;
            cauda       <= '0;
            contagem    <= '0;
            erro        <= 1'b0;
        end else begin
            estado      <= estado_nx;
            origem_pend <= origem_pend_nx;
            contagem    <= contagem_nx;
            erro        <= rejeita;
            if (pop)    cabeca <= avanca(cabeca, 1);
            if (commit) cauda  <= avanca(cauda, int'(necessarias));
        end
    end

    fila_paradas_mem #(
        .DEPTH (DEPTH),
        .W     ($bits(entrada_t))
    ) u_mem (
        .clock      (clock),
        .we0        (commit),
        .addr0      (cauda),
        .data0      (escrita0),
        .we1        (commit && !coalesce),
        .addr1      (cauda_mais1),
        .data1      (escrita1),
`ifdef FILA_COALESCE_EN
        .set_origem (commit && coalesce),
        .addr_ult   (cauda_ant),
        .dado_ult   (ultima),
`endif
        .addr_rd    (cabeca),
        .dado_rd    (cabeca_ent)
    );

    assign vazia       = (contagem == '0);
    assign prox_parada = vazia ? VAZIO : cabeca_ent.andar;
    assign eh_origem   = !vazia && cabeca_ent.origem;
    assign cheia       = (DEPTH_C - contagem) < CNT_W'(2);
    assign ocupacao    = contagem;

endmodule

// File: tb/tb_fila_paradas.sv
// Self-checking bench for fila_paradas: cycle table for basic/invalid/clear cases,
// scoreboard queue of expected stops for full, wrap-around and simultaneous shift+commit.
module tb_fila_paradas;

    localparam int DEPTH   = 8;
    localparam int ANDAR_W = 4;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic               clock = 1'b0;
    logic               reset, clear, grava_origem, grava_destino, shift;
    logic [ANDAR_W-1:0] andar_entrada;
    logic [ANDAR_W-1:0] prox_parada;
    logic               eh_origem, vazia, cheia, erro;
    logic [CNT_W-1:0]   ocupacao;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      nome;
        logic       go, gd, sh, cl;
        logic [3:0] a;
        logic [3:0] prox;
        logic       eh;
        int         ocup;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] andar;
        logic       origem;
    } ent_t;

    vec_t tbl[$];
    ent_t sb[$];

    fila_paradas #(.DEPTH(DEPTH), .ANDAR_W(ANDAR_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .grava_origem  (grava_origem),
        .grava_destino (grava_destino),
        .andar_entrada (andar_entrada),
        .shift         (shift),
        .prox_parada   (prox_parada),
        .eh_origem     (eh_origem),
        .vazia         (vazia),
        .cheia         (cheia),
        .ocupacao      (ocupacao),
        .erro          (erro)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nome, actual, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] prox, input logic eh,
                             input int ocup, input logic err);
        check({tag, ".prox_parada"}, 32'(prox_parada), 32'(prox));
        check({tag, ".eh_origem"},   32'(eh_origem),   32'(eh));
        check({tag, ".ocupacao"},    32'(ocupacao),    32'(ocup));
        check({tag, ".vazia"},       32'(vazia),       32'(ocup == 0));
        check({tag, ".cheia"},       32'(cheia),       32'((DEPTH - ocup) < 2));
        check({tag, ".erro"},        32'(erro),        32'(err));
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic go, input logic gd, input logic sh, input logic cl,
                        input logic [3:0] a);
        grava_origem  = go;
        grava_destino = gd;
        shift         = sh;
        clear         = cl;
        andar_entrada = a;
        @(posedge clock);
        #1;
        grava_origem  = 1'b0;
        grava_destino = 1'b0;
        shift         = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic add(input string nome, input logic go, input logic gd, input logic sh,
                       input logic cl, input logic [3:0] a, input logic [3:0] prox,
                       input logic eh, input int ocup, input logic err);
        vec_t v;
        v.nome = nome; v.go = go; v.gd = gd; v.sh = sh; v.cl = cl; v.a = a;
        v.prox = prox; v.eh = eh; v.ocup = ocup; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic head_vs_sb(input string tag);
        if (sb.size() == 0) begin
            check({tag, ".head"}, 32'(prox_parada), 32'(0));
        end else begin
            check({tag, ".head"},   32'(prox_parada), 32'(sb[0].andar));
            check({tag, ".origem"}, 32'(eh_origem),   32'(sb[0].origem));
        end
    endtask

    task automatic commit_pair(input string tag, input logic [3:0] o, input logic [3:0] d,
                               input logic ok);
        ent_t e;
        step(1, 0, 0, 0, o);
        check({tag, ".erro_orig"}, 32'(erro), 32'(0));
        step(0, 1, 0, 0, d);
        if (ok) begin
            e.andar = o; e.origem = 1'b1; sb.push_back(e);
            e.andar = d; e.origem = 1'b0; sb.push_back(e);
        end
        check({tag, ".erro"},     32'(erro),     32'(!ok));
        check({tag, ".ocupacao"}, 32'(ocupacao), 32'(sb.size()));
        check({tag, ".cheia"},    32'(cheia),    32'((DEPTH - sb.size()) < 2));
        head_vs_sb(tag);
    endtask

    task automatic pop_check(input string tag);
        head_vs_sb(tag);
        step(0, 0, 1, 0, 0);
        if (sb.size() != 0) void'(sb.pop_front());
        check({tag, ".ocupacao"}, 32'(ocupacao), 32'(sb.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ent_t e;
        reset = 1'b1; clear = 1'b0; grava_origem = 1'b0; grava_destino = 1'b0;
        shift = 1'b0; andar_entrada = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_out("reset", 0, 0, 0, 0);

        //   name           go gd sh cl  a   prox eh ocup err
        add("idle",          0, 0, 0, 0, 0,  0,   0, 0,   0);
        add("orig3",         1, 0, 0, 0, 3,  0,   0, 0,   0);
        add("dest7",         0, 1, 0, 0, 7,  3,   1, 2,   0);
        add("shift1",        0, 0, 1, 0, 0,  7,   0, 1,   0);
        add("shift2",        0, 0, 1, 0, 0,  0,   0, 0,   0);
        add("shift_empty",   0, 0, 1, 0, 0,  0,   0, 0,   0);
        add("orig5",         1, 0, 0, 0, 5,  0,   0, 0,   0);
        add("dest5_same",    0, 1, 0, 0, 5,  0,   0, 0,   1);
        add("erro_drops",    0, 0, 0, 0, 0,  0,   0, 0,   0);
        add("orig0",         1, 0, 0, 0, 0,  0,   0, 0,   1);
        add("dest_in_idle",  0, 1, 0, 0, 6,  0,   0, 0,   0);
        add("orig4",         1, 0, 0, 0, 4,  0,   0, 0,   0);
        add("dest0",         0, 1, 0, 0, 0,  0,   0, 0,   1);
        add("both_idle",     1, 1, 0, 0, 2,  0,   0, 0,   0);
        add("orig2",         1, 0, 0, 0, 2,  0,   0, 0,   0);
        add("clear",         0, 0, 0, 1, 0,  0,   0, 0,   0);
        add("dest6_post_clr",0, 1, 0, 0, 6,  0,   0, 0,   0);
        add("orig9",         1, 0, 0, 0, 9,  0,   0, 0,   0);
        add("reorig8",       1, 0, 0, 0, 8,  0,   0, 0,   0);
        add("dest9_vs_8",    0, 1, 0, 0, 9,  8,   1, 2,   0);
        add("drop8",         0, 0, 1, 0, 0,  9,   0, 1,   0);
        add("drop9",         0, 0, 1, 0, 0,  0,   0, 0,   0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].go, tbl[i].gd, tbl[i].sh, tbl[i].cl, tbl[i].a);
            check_out(tbl[i].nome, tbl[i].prox, tbl[i].eh, tbl[i].ocup, tbl[i].err);
        end

        // Full queue, rejected fifth pair, wrap-around.
        commit_pair("p1", 1, 2, 1);
        commit_pair("p2", 3, 4, 1);
        commit_pair("p3", 5, 6, 1);
        commit_pair("p4", 7, 8, 1);
        commit_pair("p5_full", 9, 10, 0);
        step(0, 0, 0, 0, 0);
        check("erro_one_cycle", 32'(erro), 32'(0));
        pop_check("pop_a");
        pop_check("pop_b");
        commit_pair("p6_wrap", 11, 12, 1);
        pop_check("pop_c");

        // Seven valid entries: shift and commit on the same edge.
        step(1, 0, 0, 0, 13);
        head_vs_sb("simul_pre");
        step(0, 1, 1, 0, 14);
        void'(sb.pop_front());
        e.andar = 13; e.origem = 1'b1; sb.push_back(e);
        e.andar = 14; e.origem = 1'b0; sb.push_back(e);
        check("simul.ocupacao", 32'(ocupacao), 32'(8));
        check("simul.erro",     32'(erro),     32'(0));
        check("simul.cheia",    32'(cheia),    32'(1));

        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
        check_out("drained", 0, 0, 0, 0);

        // Reset held during ESPERA_DESTINO discards the pending origin.
        step(1, 0, 0, 0, 3);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 1, 0, 0, 5);
        check_out("reset_mid_req", 0, 0, 0, 0);

`ifdef FILA_COALESCE_EN
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 4);
        step(1, 0, 0, 0, 4);
        step(0, 1, 0, 0, 9);
        e.andar = 1; e.origem = 1'b1; sb.push_back(e);
        e.andar = 4; e.origem = 1'b1; sb.push_back(e);
        e.andar = 9; e.origem = 1'b0; sb.push_back(e);
        check("coal.ocupacao", 32'(ocupacao), 32'(3));
        check("coal.erro",     32'(erro),     32'(0));
        for (int i = 0; i < 3; i++) pop_check($sformatf("coal_pop%0d", i));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
